// File: rtl/fadd_share_sched_if.sv
// fadd_share_sched_if: requester handshake and float_add operand/result bus for the shared-adder scheduler
interface fadd_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         add_dataa;
  logic [WIDTH-1:0]         add_datab;
  logic [WIDTH-1:0]         add_result;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     busy;
  modport slave (
    input  req_valid, req_a, req_b, add_result,
    output req_ready, add_dataa, add_datab, rsp_valid, rsp_data, busy
  );
  modport master (
    output req_valid, req_a, req_b, add_result,
    input  req_ready, add_dataa, add_datab, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fadd_share_sched.sv
// fadd_share_sched: round-robin sharing of one pipelined float_add among NUM_REQ requesters
module fadd_share_sched #(
  parameter int NUM_REQ     = 4,
  parameter int ADD_LATENCY = 7,
  parameter int WIDTH       = 32
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic               clk_en,
  fadd_share_sched_if.slave  bus
);
  localparam int IW   = $clog2(NUM_REQ);
  localparam int LAST = ADD_LATENCY + 1;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, gnt_id;
  logic [IW:0]      idx;
  logic             hit;
  logic [WIDTH-1:0] dataa_q, dataa_d, datab_q, datab_d;
  logic [LAST:0]    tag_v_q;
  logic [IW-1:0]    tag_id_q [LAST+1];
  // Scan from the highest offset down so the entry closest to rr_ptr wins.
  always_comb begin
    hit    = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(NUM_REQ)) ? idx - (IW+1)'(NUM_REQ) : idx;
      if (bus.req_valid[idx[IW-1:0]]) begin
        hit    = 1'b1;
        gnt_id = idx[IW-1:0];
      end
    end
    hit      = hit & clk_en & ~aclr;
    rr_ptr_d = hit ? ((gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
    dataa_d  = hit ? bus.req_a[gnt_id*WIDTH +: WIDTH] : '0;
    datab_d  = hit ? bus.req_b[gnt_id*WIDTH +: WIDTH] : '0;
  end
  // Tag stage 0 sits beside the operand registers; the remaining ADD_LATENCY+1
  // stages follow the operands through the adder's sample register and pipeline.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      rr_ptr_q <= '0;
      dataa_q  <= '0;
      datab_q  <= '0;
      tag_v_q  <= '0;
      for (int k = 0; k <= LAST; k++) tag_id_q[k] <= '0;
    end else if (clk_en) begin
      rr_ptr_q    <= rr_ptr_d;
      dataa_q     <= dataa_d;
      datab_q     <= datab_d;
      tag_v_q     <= {tag_v_q[LAST-1:0], hit};
      tag_id_q[0] <= gnt_id;
      for (int k = 1; k <= LAST; k++) tag_id_q[k] <= tag_id_q[k-1];
    end
  end
  assign bus.req_ready = hit ? NUM_REQ'(1) << gnt_id : '0;
  assign bus.add_dataa = dataa_q;
  assign bus.add_datab = datab_q;
  assign bus.rsp_valid = (tag_v_q[LAST] && clk_en) ? NUM_REQ'(1) << tag_id_q[LAST] : '0;
  assign bus.rsp_data  = bus.add_result;
  assign bus.busy      = |tag_v_q;
endmodule

// File: tb/tb_fadd_share_sched.sv
// tb_fadd_share_sched: directed table plus corner sequences against a behavioural float_add
module tb_fadd_share_sched;
  localparam int L = 7;
  logic clk = 1'b0, aclr = 1'b1, clk_en = 1'b1;
  int chk = 0, err = 0;
  fadd_share_sched_if #(.NUM_REQ(4), .WIDTH(32)) bus ();
  fadd_share_sched #(.NUM_REQ(4), .ADD_LATENCY(L), .WIDTH(32)) dut (
    .clock(clk), .aclr(aclr), .clk_en(clk_en), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    e = {3'b000, x[30:23]} + 11'd896;
    return (x[30:0] == 0) ? 0.0 : $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return (b[62:0] == 0) ? {b[63], 31'd0} : {b[63], e[7:0], b[51:29]};
  endfunction
  // float_add model: samples operands on an enabled edge, result L enabled edges later
  logic [31:0] pipe [0:L];
  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k <= L; k++) pipe[k] <= '0;
    end else if (clk_en) begin
      pipe[0] <= r2sp(sp2r(bus.add_dataa) + sp2r(bus.add_datab));
      for (int k = 1; k <= L; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign bus.add_result = pipe[L];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  typedef struct packed {
    logic [3:0]  v;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        busy;
    logic [31:0] da;
  } vec_t;
  vec_t tbl [24];
  int seen, first;
  logic [3:0] rv;
  logic [31:0] rd;
  logic bz;
  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 4'b0000, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{4'b1111, 4'b0010, 4'b0000, 32'h0,        1'b1, 32'h3F800000};
    tbl[2]  = '{4'b1111, 4'b0100, 4'b0000, 32'h0,        1'b1, 32'h40000000};
    tbl[3]  = '{4'b1111, 4'b1000, 4'b0000, 32'h0,        1'b1, 32'h40400000};
    tbl[4]  = '{4'b1111, 4'b0001, 4'b0000, 32'h0,        1'b1, 32'h40800000};
    tbl[5]  = '{4'b1111, 4'b0010, 4'b0000, 32'h0,        1'b1, 32'h3F800000};
    tbl[6]  = '{4'b1111, 4'b0100, 4'b0000, 32'h0,        1'b1, 32'h40000000};
    tbl[7]  = '{4'b1111, 4'b1000, 4'b0000, 32'h0,        1'b1, 32'h40400000};
    tbl[8]  = '{4'b0100, 4'b0100, 4'b0000, 32'h0,        1'b1, 32'h40800000};
    tbl[9]  = '{4'b0011, 4'b0001, 4'b0001, 32'h40000000, 1'b1, 32'h40400000};
    tbl[10] = '{4'b0010, 4'b0010, 4'b0010, 32'h40400000, 1'b1, 32'h3F800000};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0100, 32'h40800000, 1'b1, 32'h40000000};
    tbl[12] = '{4'b0000, 4'b0000, 4'b1000, 32'h40A00000, 1'b1, 32'h0};
    tbl[13] = '{4'b0001, 4'b0001, 4'b0001, 32'h40000000, 1'b1, 32'h0};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0010, 32'h40400000, 1'b1, 32'h3F800000};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0100, 32'h40800000, 1'b1, 32'h0};
    tbl[16] = '{4'b0000, 4'b0000, 4'b1000, 32'h40A00000, 1'b1, 32'h0};
    tbl[17] = '{4'b0000, 4'b0000, 4'b0100, 32'h40800000, 1'b1, 32'h0};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0001, 32'h40000000, 1'b1, 32'h0};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0010, 32'h40400000, 1'b1, 32'h0};
    tbl[20] = '{4'b0000, 4'b0000, 4'b0000, 32'h0,        1'b1, 32'h0};
    tbl[21] = '{4'b0000, 4'b0000, 4'b0000, 32'h0,        1'b1, 32'h0};
    tbl[22] = '{4'b0000, 4'b0000, 4'b0001, 32'h40000000, 1'b1, 32'h0};
    tbl[23] = '{4'b0000, 4'b0000, 4'b0000, 32'h0,        1'b0, 32'h0};
    bus.req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    bus.req_b = {4{32'h3F800000}};
    bus.req_valid = 4'b1111;
    // reset state with requests pending
    @(negedge clk); #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_rsp", 32'(bus.rsp_valid), 32'h0);
    check("rst_dataa", bus.add_dataa, 32'h0);
    check("rst_datab", bus.add_datab, 32'h0);
    @(negedge clk);
    aclr = 1'b0;
    bus.req_valid = 4'b0000;
    // contention, pointer wrap, idle bubble
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.req_valid = tbl[i].v;
      #1;
      check($sformatf("t%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      check($sformatf("t%0d_rspv", i), 32'(bus.rsp_valid), 32'(tbl[i].rv));
      if (tbl[i].rv != 0) check($sformatf("t%0d_rspd", i), bus.rsp_data, tbl[i].rd);
      check($sformatf("t%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("t%0d_dataa", i), bus.add_dataa, tbl[i].da);
      check($sformatf("t%0d_datab", i), bus.add_datab, (tbl[i].da != 0) ? 32'h3F800000 : 32'h0);
    end
    // single issue 1.0 + 2.0 from requester 2
    @(negedge clk);
    bus.req_a[95:64] = 32'h3F800000;
    bus.req_b[95:64] = 32'h40000000;
    bus.req_valid = 4'b0100;
    #1;
    check("s1_ready", 32'(bus.req_ready), 32'h4);
    seen = 0; first = 0; bz = 1'b1; rv = '0; rd = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b0000;
      #1;
      if (bus.rsp_valid != 0) begin
        seen++;
        if (first == 0) begin first = c; rv = bus.rsp_valid; rd = bus.rsp_data; end
      end
      if (c <= 9 && !bus.busy) bz = 1'b0;
    end
    check("s1_latency", 32'(first), 32'(L + 2));
    check("s1_rspv", 32'(rv), 32'h4);
    check("s1_rspd", rd, 32'h40400000);
    check("s1_once", 32'(seen), 32'h1);
    check("s1_busy", 32'(bz), 32'h1);
    // clk_en low for 3 cycles mid-flight
    @(negedge clk);
    bus.req_valid = 4'b0001;
    #1;
    check("s2_ready", 32'(bus.req_ready), 32'h1);
    seen = 0; first = 0; rv = '0; rd = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      clk_en = !(c >= 4 && c <= 6);
      bus.req_valid = clk_en ? 4'b0000 : 4'b1111;
      #1;
      if (!clk_en) begin
        check($sformatf("s2_frz_ready%0d", c), 32'(bus.req_ready), 32'h0);
        check($sformatf("s2_frz_rspv%0d", c), 32'(bus.rsp_valid), 32'h0);
        check($sformatf("s2_frz_busy%0d", c), 32'(bus.busy), 32'h1);
      end
      if (bus.rsp_valid != 0) begin
        seen++;
        if (first == 0) begin first = c; rv = bus.rsp_valid; rd = bus.rsp_data; end
      end
    end
    check("s2_latency", 32'(first), 32'(L + 5));
    check("s2_rspv", 32'(rv), 32'h1);
    check("s2_rspd", rd, 32'h40000000);
    check("s2_once", 32'(seen), 32'h1);
    // aclr with four operations in flight
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.req_valid = 4'b1111;
    end
    @(negedge clk);
    aclr = 1'b1;
    #1;
    check("s3_ready", 32'(bus.req_ready), 32'h0);
    check("s3_busy", 32'(bus.busy), 32'h0);
    check("s3_rspv", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    aclr = 1'b0;
    bus.req_valid = 4'b0000;
    for (int c = 1; c <= 2 * L; c++) begin
      @(negedge clk); #1;
      check($sformatf("s3_quiet%0d", c), 32'({bus.busy, bus.rsp_valid}), 32'h0);
    end
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    check("s3_grant0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
